// File: rtl/result_drain_if.sv
// Stream bundle for result_drain: upstream capture (multiplier side) and downstream replay (consumer side).
// The master modport is the drain's view; the slave modport is the environment's view.
interface result_drain_if #(
    parameter int WIDTH = 32
);
    logic             EN_blockRead;
    logic             VALID_memVal;
    logic [WIDTH-1:0] memVal_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport master (
        output EN_blockRead,
        input  VALID_memVal,
        input  memVal_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );

    modport slave (
        input  EN_blockRead,
        output VALID_memVal,
        output memVal_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/result_drain.sv
// Captures one multiplier result block into a FIFO and replays it over valid/ready with a last marker.
// Optional RESULT_DRAIN_CHECKSUM_EN appends the low WIDTH bits of the block sum as a final word.
module result_drain #(
    parameter int LOGDEPTH  = 6,
    parameter int WIDTH     = 32,
    parameter int BLOCK_LEN = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    result_drain_if.master      bus,
    output logic [LOGDEPTH:0]   word_count,
    output logic                overflow_err
);
    localparam int DEPTH = 1 << LOGDEPTH;
    localparam logic [LOGDEPTH:0] DEPTH_C     = DEPTH[LOGDEPTH:0];
    localparam logic [LOGDEPTH:0] BLOCK_LEN_C = BLOCK_LEN[LOGDEPTH:0];
    localparam logic [LOGDEPTH:0] ONE_C       = {{LOGDEPTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, REQ, RECV, DRAIN} state_t;

    state_t                state_reg, state_next;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [LOGDEPTH-1:0]   wr_ptr_reg, rd_ptr_reg, rd_addr_next;
    logic [LOGDEPTH:0]     count_reg, count_next;
    logic [WIDTH-1:0]      out_data_reg;
    logic [LOGDEPTH:0]     word_count_reg, word_count_next;
    logic                  overflow_reg;
    logic                  burst_reg, burst_next;
    logic                  push, pop, ovf_set;
    logic [WIDTH-1:0]      push_data;
    logic                  en_read, last, done_int;

`ifdef RESULT_DRAIN_CHECKSUM_EN
    localparam int SUMW = WIDTH + LOGDEPTH + 1;
    logic [SUMW-1:0]       sum_reg;
    logic                  csum_pend_reg;
`endif

    assign pop          = (count_reg != '0) && bus.out_ready;
    assign rd_addr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + 1'b1;
        else if (pop && !push)
            count_next = count_reg - 1'b1;
    end

    always_comb begin
        state_next      = state_reg;
        push            = 1'b0;
        push_data       = bus.memVal_data;
        word_count_next = word_count_reg;
        burst_next      = burst_reg;
        ovf_set         = 1'b0;
        en_read         = 1'b0;
        last            = 1'b0;
        done_int        = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start && count_reg == '0) begin
                    state_next      = REQ;
                    word_count_next = '0;
                end
            end
            REQ: begin
                en_read = 1'b1;
                if (bus.VALID_memVal) begin
                    push            = 1'b1;
                    word_count_next = ONE_C;
                    if (word_count_next == BLOCK_LEN_C) begin
                        state_next = DRAIN;
                        burst_next = 1'b1;
                    end else begin
                        state_next = RECV;
                    end
                end
            end
            RECV: begin
                if (bus.VALID_memVal) begin
                    push            = 1'b1;
                    word_count_next = word_count_reg + 1'b1;
                    if (word_count_next == BLOCK_LEN_C) begin
                        state_next = DRAIN;
                        burst_next = 1'b1;
                    end
                end else begin
`ifdef RESULT_DRAIN_CHECKSUM_EN
                    state_next = DRAIN;
`else
                    // End is detected this cycle, so a sole remaining head is already the last word.
                    last = (count_reg == ONE_C);
                    if (pop && last) begin
                        done_int   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = DRAIN;
                    end
`endif
                end
            end
            DRAIN: begin
                // Words trailing a block that filled to BLOCK_LEN are dropped and flagged.
                if (burst_reg) begin
                    if (bus.VALID_memVal)
                        ovf_set = 1'b1;
                    else
                        burst_next = 1'b0;
                end
`ifdef RESULT_DRAIN_CHECKSUM_EN
                if (csum_pend_reg) begin
                    if (count_reg != DEPTH_C) begin
                        push      = 1'b1;
                        push_data = sum_reg[WIDTH-1:0];
                    end
                end else begin
                    last = (count_reg == ONE_C);
                    if (pop && last) begin
                        done_int   = 1'b1;
                        state_next = IDLE;
                        burst_next = 1'b0;
                    end
                end
`else
                last = (count_reg == ONE_C);
                if (pop && last) begin
                    done_int   = 1'b1;
                    state_next = IDLE;
                    burst_next = 1'b0;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            out_data_reg   <= '0;
            word_count_reg <= '0;
            overflow_reg   <= 1'b0;
            burst_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            word_count_reg <= word_count_next;
            burst_reg      <= burst_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (ovf_set)
                overflow_reg <= 1'b1;
            // Head register: bypass a word written into the slot that becomes the head.
            if (count_next == '0)
                out_data_reg <= '0;
            else if (push && wr_ptr_reg == rd_addr_next)
                out_data_reg <= push_data;
            else
                out_data_reg <= mem[rd_addr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= push_data;
    end

`ifdef RESULT_DRAIN_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg       <= '0;
            csum_pend_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && state_next == REQ)
                sum_reg <= '0;
            else if (push && state_reg != DRAIN)
                sum_reg <= sum_reg + SUMW'(bus.memVal_data);
            if (state_reg != DRAIN && state_next == DRAIN)
                csum_pend_reg <= 1'b1;
            else if (push && state_reg == DRAIN)
                csum_pend_reg <= 1'b0;
        end
    end
`endif

    assign bus.EN_blockRead = en_read;
    assign bus.out_valid    = (count_reg != '0);
    assign bus.out_data     = out_data_reg;
    assign bus.out_last     = last;
    assign busy             = (state_reg != IDLE);
    assign done             = done_int;
    assign word_count       = word_count_reg;
    assign overflow_err     = overflow_reg;
endmodule

// File: tb/tb_result_drain.sv
// Randomized self-checking bench for result_drain: expected words, last/done markers and counts
// come from a queue-based block model; a negedge monitor checks every pop and every held head.
module tb_result_drain;
    localparam int LOGDEPTH  = 6;
    localparam int WIDTH     = 32;
    localparam int BLOCK_LEN = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               busy;
    logic               done;
    logic [LOGDEPTH:0]  word_count;
    logic               overflow_err;

    result_drain_if #(.WIDTH(WIDTH)) bus();

    result_drain #(.LOGDEPTH(LOGDEPTH), .WIDTH(WIDTH), .BLOCK_LEN(BLOCK_LEN)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .done(done),
        .bus(bus),
        .word_count(word_count),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               done_cnt = 0;
    bit               mon_en = 1'b0;
    logic             prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic rdy(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 2) == 0;
            2:       return $urandom_range(0, 1) == 1;
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        if (mon_en) begin
            if (prev_hold) begin
                check("hold_valid", 64'(bus.out_valid), 64'(1));
                check("hold_data", 64'(bus.out_data), 64'(prev_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 64'(bus.out_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("data", 64'(bus.out_data), 64'(e));
                    check("last", 64'(bus.out_last), 64'(exp_q.size() == 0));
                    check("done_pop", 64'(done), 64'(exp_q.size() == 0));
                end
            end else begin
                check("done_nopop", 64'(done), 64'(0));
            end
            if (done)
                done_cnt++;
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
        end
    end

    // mode: 0 ready always, 1 toggling, 2 random, 3 hold then pulse start while words are still queued
    task automatic run_block(input int n, input int gap, input int mode, input bit seq_data);
        logic [WIDTH-1:0] words[$];
        longint           sum;
        int               acc;
        int               k;
        int               cyc;
        sum = 0;
        cyc = 0;
        for (int i = 0; i < n; i++)
            words.push_back(seq_data ? WIDTH'(i + 1) : WIDTH'($urandom));
        acc = (n < BLOCK_LEN) ? n : BLOCK_LEN;
        for (int i = 0; i < acc; i++) begin
            exp_q.push_back(words[i]);
            sum += longint'(words[i]);
        end
`ifdef RESULT_DRAIN_CHECKSUM_EN
        exp_q.push_back(WIDTH'(sum));
`endif
        done_cnt = 0;
        @(negedge clk);
        check("idle_before", 64'(busy), 64'(0));
        @(posedge clk); #1;
        start = 1'b1;
        bus.out_ready = rdy(mode, cyc++);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < gap; c++) begin
            bus.VALID_memVal = 1'b0;
            bus.out_ready = rdy(mode, cyc++);
            @(negedge clk);
            check("en_wait", 64'(bus.EN_blockRead), 64'(1));
            @(posedge clk); #1;
        end
        for (int i = 0; i < n; i++) begin
            bus.VALID_memVal = 1'b1;
            bus.memVal_data = words[i];
            bus.out_ready = rdy(mode, cyc++);
            @(negedge clk);
            check("en_stream", 64'(bus.EN_blockRead), 64'(i == 0));
            @(posedge clk); #1;
        end
        bus.VALID_memVal = 1'b0;
        bus.memVal_data = '0;
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            if (mode == 3) begin
                bus.out_ready = (k < 10) || (k >= 15);
                start = (k == 10);
            end else begin
                bus.out_ready = rdy(mode, cyc++);
            end
            @(negedge clk);
            if (k == 0)
                check("en_after", 64'(bus.EN_blockRead), 64'(0));
            if (mode == 3 && k >= 10 && k < 15) begin
                check("ign_en", 64'(bus.EN_blockRead), 64'(0));
                check("ign_busy", 64'(busy), 64'(1));
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        bus.out_ready = 1'b0;
        check("timeout", 64'(done_cnt > 0), 64'(1));
        check("done_once", 64'(done_cnt), 64'(1));
        check("word_count", 64'(word_count), 64'(acc));
        check("q_drained", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
        check("busy_end", 64'(busy), 64'(0));
        check("empty_end", 64'(bus.out_valid), 64'(0));
        check("en_end", 64'(bus.EN_blockRead), 64'(0));
        $display("block n=%0d gap=%0d mode=%0d cycles=%0d word_count=%0d overflow=%0b",
                 n, gap, mode, k, word_count, overflow_err);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.VALID_memVal = 1'b0;
        bus.memVal_data = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_en", 64'(bus.EN_blockRead), 64'(0));
        check("rst_valid", 64'(bus.out_valid), 64'(0));
        check("rst_data", 64'(bus.out_data), 64'(0));
        check("rst_last", 64'(bus.out_last), 64'(0));
        check("rst_wc", 64'(word_count), 64'(0));
        check("rst_ovf", 64'(overflow_err), 64'(0));
        mon_en = 1'b1;

        run_block(63, 0, 0, 1'b1);
        run_block(10, 20, 0, 1'b0);
        run_block(63, 0, 1, 1'b1);
        for (int b = 0; b < 6; b++)
            run_block($urandom_range(1, BLOCK_LEN), $urandom_range(0, 5), 2, 1'b0);
        run_block(1, 0, 0, 1'b0);
        run_block(BLOCK_LEN, 1, 2, 1'b0);
        check("no_ovf_yet", 64'(overflow_err), 64'(0));

        run_block(BLOCK_LEN + 2, 2, 0, 1'b0);
        check("ovf_set", 64'(overflow_err), 64'(1));
        run_block(5, 0, 2, 1'b0);
        check("ovf_sticky", 64'(overflow_err), 64'(1));

        run_block(20, 0, 3, 1'b0);

        // Reset in the middle of a block receive
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus.VALID_memVal = 1'b1;
            bus.memVal_data = WIDTH'($urandom);
            bus.out_ready = 1'b0;
            @(posedge clk); #1;
        end
        mon_en = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_wc", 64'(word_count), 64'(30));
        check("pre_rst_busy", 64'(busy), 64'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        bus.VALID_memVal = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_en", 64'(bus.EN_blockRead), 64'(0));
        check("mid_rst_wc", 64'(word_count), 64'(0));
        check("mid_rst_ovf", 64'(overflow_err), 64'(0));
        $display("reset mid-RECV: valid=%0b busy=%0b wc=%0d ovf=%0b",
                 bus.out_valid, busy, word_count, overflow_err);
        prev_hold = 1'b0;
        mon_en = 1'b1;
        run_block(12, 1, 2, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Sits directly downstream of the multiplier block.
- Requests a block read via EN_blockRead, then captures the VALID_memVal/memVal_data stream into an internal FIFO. The multiplier's stream has no backpressure, so the FIFO is mandatory.
- Replays the captured words to a consumer over a valid/ready interface, marking the final word with out_last.
- Tracks the word count and a running sum per block.

Parameters:
- LOGDEPTH, 6: log2 of FIFO depth; FIFO holds 2^LOGDEPTH words.
- WIDTH, 32: data word width.
- BLOCK_LEN, 64: maximum words accepted per block; must be <= 2^LOGDEPTH.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request one block drain; sampled only in IDLE.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the last word of the block is popped.
- EN_blockRead  output  1  read request to the multiplier block.
- VALID_memVal  input  1  upstream word valid.
- memVal_data  input  WIDTH  upstream word.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head.
- out_data  output  WIDTH  FIFO head word.
- out_last  output  1  head is the final word of the block.
- word_count  output  LOGDEPTH+1  words captured in the current or last block.
- overflow_err  output  1  sticky: a word arrived after BLOCK_LEN was reached.

Behaviour:
- Reset values (all outputs and state):
  - busy=0, done=0, EN_blockRead=0, out_valid=0, out_data=0, out_last=0, word_count=0, overflow_err=0.
  - FIFO pointers cleared; sum cleared; state=IDLE.
  - Reset asserted mid-operation discards all FIFO contents and any block in progress; the next cycle is IDLE.
- States: IDLE, REQ, RECV, DRAIN.
- IDLE:
  - EN_blockRead=0.
  - start=1 and FIFO empty -> REQ; clear word_count and sum.
  - start=1 while FIFO is non-empty is ignored.
- REQ:
  - EN_blockRead=1, held until the first VALID_memVal=1. The upstream block may still be writing and reaches FULL later.
  - On the first VALID_memVal=1: push that word, word_count=1, go to RECV. EN_blockRead drops the following cycle.
- RECV:
  - EN_blockRead=0.
  - Each cycle with VALID_memVal=1 and word_count<BLOCK_LEN: push memVal_data, word_count+1, sum += memVal_data.
  - Sum width is WIDTH+LOGDEPTH+1 bits, zero-extended, and never wraps within a block.
  - VALID_memVal=1 with word_count==BLOCK_LEN: word dropped, overflow_err set.
  - End of block: first cycle with VALID_memVal=0, or the cycle word_count reaches BLOCK_LEN -> DRAIN.
- DRAIN:
  - Ignore VALID_memVal.
  - Stay until the final block word is popped; then pulse done and go to IDLE.
- Output interface (active in all states):
  - out_valid = FIFO non-empty; out_data is the head word, registered from FIFO storage.
  - Pop when out_valid && out_ready.
  - out_valid/out_data hold stable while out_ready=0.
- Simultaneous events:
  - Push and pop in the same cycle: occupancy unchanged, both take effect.
  - Popping the last word on the cycle it was pushed is impossible: the write-to-head latency is 1 cycle.
- out_last: high only when the head is the final word of a block whose end has already been detected, i.e. state==DRAIN and occupancy==1.
- FIFO full: cannot occur when BLOCK_LEN <= 2^LOGDEPTH, because start requires an empty FIFO.
- Pointers wrap modulo 2^LOGDEPTH.
- overflow_err clears only on rst.

Optional Feature:
- Macro: RESULT_DRAIN_CHECKSUM_EN.
- When defined:
  - After the final data word is popped, one extra word is emitted: the low WIDTH bits of sum.
  - out_last moves from the final data word to this checksum word.
  - done pulses when the checksum word is popped.
  - word_count excludes the checksum word.
- When undefined: no extra word, and the sum register is not instantiated.

Test Plan:
- Basic block: start=1; upstream asserts VALID_memVal for 63 cycles with data 1..63; out_ready=1 -> 63 words out in order, out_last on the word 63, done pulses once, word_count=63. With the macro, a 64th word equal to 2016 carries out_last.
- Delayed upstream: start=1, VALID_memVal held low for 20 cycles -> EN_blockRead high for all 20 cycles, then low one cycle after the first valid word.
- Backpressure: same 63-word stream with out_ready toggling every other cycle -> no word lost or duplicated; out_data stable while out_ready=0; done after the 63rd pop.
- Overflow: BLOCK_LEN=64, upstream sends 66 valid words -> 64 words output, overflow_err=1 and sticky, word_count=64.
- Start while non-empty: after block end with 10 words still queued, pulse start -> ignored, state stays DRAIN, no EN_blockRead until done.
- Reset mid-RECV: rst=1 after 30 words pushed -> next cycle out_valid=0, busy=0, EN_blockRead=0, word_count=0; overflow_err cleared.
